// File: rtl/enokida_wb_cache_pkg.sv
// Shared definitions for the enokida write-back cache: FSM state encoding,
// default geometry and the offset-width helper.
package cache_def;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COMPARE    = 3'd1,
    ST_WRITE_BACK = 3'd2,
    ST_ALLOCATE   = 3'd3,
    ST_FLUSH      = 3'd4
  } cache_state_e;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_INDEX_WIDTH    = 4;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Returns 0 for a single-word line, so the offset field can vanish.
  function automatic int offset_width(input int words);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < words) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/enokida_cache_array.sv
// Tag/valid/dirty storage with asynchronous clear of valid and dirty, plus the
// line data array with word-granular writes and an index/offset read port.
module enokida_cache_array #(
  parameter int TAG_WIDTH      = 10,
  parameter int INDEX_WIDTH    = 4,
  parameter int OFFSET_WIDTH   = 2,
  parameter int BEAT_WIDTH     = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [BEAT_WIDTH-1:0]  rd_offset,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   data_we,
  input  logic [BEAT_WIDTH-1:0]  wr_offset,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   meta_we,
  input  logic [TAG_WIDTH-1:0]   meta_tag,
  input  logic                   meta_valid,
  input  logic                   meta_dirty
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = LINES * WORDS_PER_LINE;
  localparam int WA_WIDTH = INDEX_WIDTH + OFFSET_WIDTH;
  localparam logic [BEAT_WIDTH-1:0] OFS_MASK = BEAT_WIDTH'(WORDS_PER_LINE - 1);

  logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [WORDS];
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [WA_WIDTH-1:0]   rd_wa;
  logic [WA_WIDTH-1:0]   wr_wa;

  // The offset mask collapses to zero when a line holds a single word.
  assign rd_wa = (WA_WIDTH'(index) << OFFSET_WIDTH) | WA_WIDTH'(rd_offset & OFS_MASK);
  assign wr_wa = (WA_WIDTH'(index) << OFFSET_WIDTH) | WA_WIDTH'(wr_offset & OFS_MASK);

  assign rd_tag   = tag_mem[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_data  = data_mem[rd_wa];

  always_ff @(posedge clk) begin
    if (data_we) data_mem[wr_wa] <= wr_data;
    if (meta_we) tag_mem[index] <= meta_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[index] <= meta_valid;
      dirty_q[index] <= meta_dirty;
    end
  end

endmodule

// File: rtl/enokida_wb_cache.sv
// Direct-mapped write-back cache controller with multi-word lines, burst
// write-back/refill and a whole-cache flush.
module enokida_wb_cache
  import cache_def::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_data,
  input  logic                  cpu_req_rw,
  input  logic                  cpu_req_valid,
  output logic [DATA_WIDTH-1:0] cpu_res_data,
  output logic                  cpu_res_ready,
  output logic                  cpu_res_checked,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  output logic                  mem_req_rw,
  output logic                  mem_req_valid,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output cache_state_e          state_dbg
);

  // Handshakes: a cpu request is held stable with cpu_req_valid until the
  // one-cycle cpu_res_ready pulse; a memory beat completes on a cycle where
  // mem_req_valid && mem_ready, and the next beat is presented the cycle after.

  localparam int OFFSET_WIDTH = offset_width(WORDS_PER_LINE);
  localparam int BEAT_WIDTH   = (OFFSET_WIDTH > 0) ? OFFSET_WIDTH : 1;
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES        = 1 << INDEX_WIDTH;
  localparam logic [BEAT_WIDTH-1:0]  LAST_BEAT  = BEAT_WIDTH'(WORDS_PER_LINE - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(LINES - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  rw;
  } cpu_req_t;

  cache_state_e            state_q, state_nxt;
  cpu_req_t                req_q;
  logic                    capture;
  logic [BEAT_WIDTH-1:0]   beat_q, beat_nxt;
  logic [INDEX_WIDTH-1:0]  flush_idx_q, flush_idx_nxt;
  logic [DATA_WIDTH-1:0]   res_data_q, res_data_nxt;
  logic                    res_ready_q, res_ready_nxt;
  logic                    flush_done_q, flush_done_nxt;

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [BEAT_WIDTH-1:0]   req_offset;

  logic [INDEX_WIDTH-1:0]  arr_index;
  logic [BEAT_WIDTH-1:0]   rd_offset;
  logic [TAG_WIDTH-1:0]    rd_tag;
  logic                    rd_valid;
  logic                    rd_dirty;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    data_we;
  logic [BEAT_WIDTH-1:0]   wr_offset;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    meta_we;
  logic [TAG_WIDTH-1:0]    meta_tag;
  logic                    meta_valid;
  logic                    meta_dirty;
  logic                    line_done;

  function automatic logic [ADDR_WIDTH-1:0] make_addr(
    input logic [TAG_WIDTH-1:0]   tag,
    input logic [INDEX_WIDTH-1:0] idx,
    input logic [BEAT_WIDTH-1:0]  beat
  );
    return (ADDR_WIDTH'(tag) << (INDEX_WIDTH + OFFSET_WIDTH))
         | (ADDR_WIDTH'(idx) << OFFSET_WIDTH)
         | (ADDR_WIDTH'(beat) & ADDR_WIDTH'(WORDS_PER_LINE - 1));
  endfunction

  assign req_tag    = TAG_WIDTH'(req_q.addr >> (INDEX_WIDTH + OFFSET_WIDTH));
  assign req_index  = INDEX_WIDTH'(req_q.addr >> OFFSET_WIDTH);
  assign req_offset = BEAT_WIDTH'(req_q.addr & ADDR_WIDTH'(WORDS_PER_LINE - 1));

  enokida_cache_array #(
    .TAG_WIDTH      (TAG_WIDTH),
    .INDEX_WIDTH    (INDEX_WIDTH),
    .OFFSET_WIDTH   (OFFSET_WIDTH),
    .BEAT_WIDTH     (BEAT_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (arr_index),
    .rd_offset  (rd_offset),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_data    (rd_data),
    .data_we    (data_we),
    .wr_offset  (wr_offset),
    .wr_data    (wr_data),
    .meta_we    (meta_we),
    .meta_tag   (meta_tag),
    .meta_valid (meta_valid),
    .meta_dirty (meta_dirty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      beat_q       <= '0;
      flush_idx_q  <= '0;
      res_data_q   <= '0;
      res_ready_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      beat_q       <= beat_nxt;
      flush_idx_q  <= flush_idx_nxt;
      res_data_q   <= res_data_nxt;
      res_ready_q  <= res_ready_nxt;
      flush_done_q <= flush_done_nxt;
      if (capture) req_q <= '{addr: cpu_req_addr, data: cpu_req_data, rw: cpu_req_rw};
    end
  end

  always_comb begin
    state_nxt      = state_q;
    beat_nxt       = beat_q;
    flush_idx_nxt  = flush_idx_q;
    res_data_nxt   = res_data_q;
    res_ready_nxt  = 1'b0;
    flush_done_nxt = 1'b0;
    capture        = 1'b0;
    arr_index      = req_index;
    rd_offset      = req_offset;
    data_we        = 1'b0;
    wr_offset      = req_offset;
    wr_data        = req_q.data;
    meta_we        = 1'b0;
    meta_tag       = req_tag;
    meta_valid     = 1'b0;
    meta_dirty     = 1'b0;
    line_done      = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_nxt     = ST_FLUSH;
          flush_idx_nxt = '0;
          beat_nxt      = '0;
        end else if (cpu_req_valid && !res_ready_q) begin
          // The request is still asserted during its own result cycle.
          state_nxt = ST_COMPARE;
          capture   = 1'b1;
        end
      end

      ST_COMPARE: begin
        if (rd_valid && (rd_tag == req_tag)) begin
          res_ready_nxt = 1'b1;
          state_nxt     = ST_IDLE;
          if (req_q.rw) begin
            data_we      = 1'b1;
            meta_we      = 1'b1;
            meta_valid   = 1'b1;
            meta_dirty   = 1'b1;
            res_data_nxt = req_q.data;
          end else begin
            res_data_nxt = rd_data;
          end
        end else begin
          beat_nxt  = '0;
          state_nxt = (rd_valid && rd_dirty) ? ST_WRITE_BACK : ST_ALLOCATE;
        end
      end

      ST_WRITE_BACK: begin
        rd_offset     = beat_q;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = make_addr(rd_tag, req_index, beat_q);
        mem_req_data  = rd_data;
        if (mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = ST_ALLOCATE;
          end else begin
            beat_nxt = beat_q + 1'b1;
          end
        end
      end

      ST_ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = make_addr(req_tag, req_index, beat_q);
        if (mem_ready) begin
          data_we   = 1'b1;
          wr_offset = beat_q;
          wr_data   = mem_data;
          if (beat_q == LAST_BEAT) begin
            // Tag and valid are only committed once the whole line is in.
            meta_we    = 1'b1;
            meta_valid = 1'b1;
            beat_nxt   = '0;
            state_nxt  = ST_COMPARE;
          end else begin
            beat_nxt = beat_q + 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        arr_index = flush_idx_q;
        rd_offset = beat_q;
        if (rd_valid && rd_dirty) begin
          mem_req_valid = 1'b1;
          mem_req_rw    = 1'b1;
          mem_req_addr  = make_addr(rd_tag, flush_idx_q, beat_q);
          mem_req_data  = rd_data;
          if (mem_ready) begin
            line_done = (beat_q == LAST_BEAT);
            beat_nxt  = line_done ? '0 : beat_q + 1'b1;
          end
        end else begin
          line_done = 1'b1;
        end
        if (line_done) begin
          meta_we  = 1'b1;
          meta_tag = rd_tag;
          if (flush_idx_q == LAST_INDEX) begin
            flush_done_nxt = 1'b1;
            state_nxt      = ST_IDLE;
          end else begin
            flush_idx_nxt = flush_idx_q + 1'b1;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cpu_res_data    = res_data_q;
  assign cpu_res_ready   = res_ready_q;
  assign cpu_res_checked = res_ready_q;
  assign flush_done      = flush_done_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_enokida_wb_cache.sv
// Directed bench for enokida_wb_cache: a random-latency word memory, a
// reference memory for expected read data and a log of completed beats.
module tb_enokida_wb_cache;
  import cache_def::*;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_req_addr;
  logic [31:0] cpu_req_data;
  logic        cpu_req_rw;
  logic        cpu_req_valid;
  logic [31:0] cpu_res_data;
  logic        cpu_res_ready;
  logic        cpu_res_checked;
  logic        flush;
  logic        flush_done;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_req_rw;
  logic        mem_req_valid;
  logic [31:0] mem_data;
  logic        mem_ready;
  cache_state_e state_dbg;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        rw;
  } beat_t;

  logic [31:0] exp_q[$];
  beat_t       beat_log[$];
  logic [31:0] mem_model [65536];
  logic [31:0] ref_mem   [65536];
  int          tests_run;
  int          tests_failed;

  enokida_wb_cache dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_data    (cpu_req_data),
    .cpu_req_rw      (cpu_req_rw),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_res_data    (cpu_res_data),
    .cpu_res_ready   (cpu_res_ready),
    .cpu_res_checked (cpu_res_checked),
    .flush           (flush),
    .flush_done      (flush_done),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_req_rw      (mem_req_rw),
    .mem_req_valid   (mem_req_valid),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory responder: decides ready at the falling edge, so a logged beat
  // completes at the following rising edge
  initial begin
    mem_ready = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !rst) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        mem_data  = mem_model[mem_req_addr];
        if (mem_ready) begin
          beat_log.push_back('{addr: mem_req_addr, data: mem_req_data, rw: mem_req_rw});
          if (mem_req_rw) mem_model[mem_req_addr] = mem_req_data;
        end
      end else begin
        mem_ready = 1'b0;
        mem_data  = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(input string tag, output int lat);
    logic [31:0] e;
    lat = 0;
    while (cpu_res_ready !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    cpu_req_valid = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_ready"}, 64'(cpu_res_ready), 64'(1));
    check({tag, "_data"}, 64'(cpu_res_data), 64'(e));
    check({tag, "_checked"}, 64'(cpu_res_checked), 64'(1));
  endtask

  task automatic do_req(input string tag, input logic [15:0] a, input logic rw,
                        input logic [31:0] d, output int lat);
    exp_q.push_back(rw ? d : ref_mem[a]);
    if (rw) ref_mem[a] = d;
    @(negedge clk);
    cpu_req_addr  = a;
    cpu_req_data  = d;
    cpu_req_rw    = rw;
    cpu_req_valid = 1'b1;
    wait_result(tag, lat);
  endtask

  task automatic check_burst(input string tag, input logic [15:0] base, input logic rw);
    beat_t b;
    check({tag, "_beats_present"}, 64'(beat_log.size() >= 4), 64'(1));
    for (int i = 0; i < 4; i++) begin
      if (beat_log.size() > 0) begin
        b = beat_log.pop_front();
        check($sformatf("%s_addr%0d", tag, i), 64'(b.addr), 64'(base + 16'(i)));
        check($sformatf("%s_rw%0d", tag, i), 64'(b.rw), 64'(rw));
        if (rw) check($sformatf("%s_data%0d", tag, i), 64'(b.data), 64'(ref_mem[b.addr]));
      end
    end
  endtask

  task automatic pulse_flush_and_wait(input string tag);
    int n;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (flush_done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(flush_done), 64'(1));
  endtask

  initial begin
    int lat;
    int n;
    logic early;
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_data  = '0;
    cpu_req_rw    = 1'b0;
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem_model[i] = 32'h1000_0000 | 32'(i);
    end
    for (int i = 0; i < 4; i++) mem_model[16'h0040 + i] = 32'hA0 + 32'(i);
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem_model[i];

    // reset state
    @(negedge clk);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    check("reset_mem_valid", 64'(mem_req_valid), 64'(0));
    check("reset_mem_addr", 64'(mem_req_addr), 64'(0));
    check("reset_res_ready", 64'(cpu_res_ready), 64'(0));
    check("reset_res_checked", 64'(cpu_res_checked), 64'(0));
    check("reset_res_data", 64'(cpu_res_data), 64'(0));
    check("reset_flush_done", 64'(flush_done), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // 1: cold read refills the line
    do_req("t1_cold_read", 16'h0040, 1'b0, 32'h0, lat);
    check("t1_beat_count", 64'(beat_log.size()), 64'(4));
    check_burst("t1_refill", 16'h0040, 1'b0);

    // 2: hit read, two-cycle latency, no memory traffic
    do_req("t2_hit_read", 16'h0041, 1'b0, 32'h0, lat);
    check("t2_latency", 64'(lat), 64'(2));
    check("t2_no_beats", 64'(beat_log.size()), 64'(0));

    // 3: write hit dirties the line; conflicting read evicts it
    do_req("t3_write_hit", 16'h0042, 1'b1, 32'hDEADBEEF, lat);
    check("t3_write_latency", 64'(lat), 64'(2));
    check("t3_write_no_beats", 64'(beat_log.size()), 64'(0));
    do_req("t3_conflict_read", 16'h0442, 1'b0, 32'h0, lat);
    check("t3_beat_count", 64'(beat_log.size()), 64'(8));
    check_burst("t3_writeback", 16'h0040, 1'b1);
    check_burst("t3_refill", 16'h0440, 1'b0);

    // 4: dirty lines at index 0 and 3, then a whole-cache flush
    do_req("t4_dirty_idx0", 16'h0440, 1'b1, 32'h1111_1111, lat);
    do_req("t4_dirty_idx3", 16'h000C, 1'b1, 32'h2222_2222, lat);
    beat_log.delete();
    pulse_flush_and_wait("t4_flush");
    @(negedge clk);
    check("t4_done_one_cycle", 64'(flush_done), 64'(0));
    check("t4_beat_count", 64'(beat_log.size()), 64'(8));
    check_burst("t4_wb_idx0", 16'h0440, 1'b1);
    check_burst("t4_wb_idx3", 16'h000C, 1'b1);
    do_req("t4_reread", 16'h0040, 1'b0, 32'h0, lat);
    check("t4_reread_beats", 64'(beat_log.size()), 64'(4));
    check_burst("t4_reread_refill", 16'h0040, 1'b0);

    // 5: reset during allocate beat 2
    @(negedge clk);
    cpu_req_addr  = 16'h0C40;
    cpu_req_rw    = 1'b0;
    cpu_req_valid = 1'b1;
    n = 0;
    while (!(mem_req_valid === 1'b1 && mem_req_addr === 16'h0C42) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_beat2", 64'(n < 200), 64'(1));
    cpu_req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_mem_valid_drop", 64'(mem_req_valid), 64'(0));
    check("t5_state_idle", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    beat_log.delete();
    do_req("t5_after_reset", 16'h0040, 1'b0, 32'h0, lat);
    check("t5_miss_beats", 64'(beat_log.size()), 64'(4));
    check_burst("t5_refill", 16'h0040, 1'b0);

    // 6: flush and request in the same idle cycle
    do_req("t6_dirty_idx1", 16'h0085, 1'b1, 32'h5555_AAAA, lat);
    beat_log.delete();
    exp_q.push_back(ref_mem[16'h0085]);
    @(negedge clk);
    flush         = 1'b1;
    cpu_req_addr  = 16'h0085;
    cpu_req_rw    = 1'b0;
    cpu_req_data  = '0;
    cpu_req_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n     = 0;
    early = 1'b0;
    while (flush_done !== 1'b1 && n < 500) begin
      if (cpu_res_ready === 1'b1) early = 1'b1;
      @(negedge clk);
      n++;
    end
    check("t6_flush_done", 64'(flush_done), 64'(1));
    check("t6_no_early_result", 64'(early), 64'(0));
    wait_result("t6_read_after_flush", lat);
    check("t6_beat_count", 64'(beat_log.size()), 64'(8));
    check_burst("t6_flush_wb", 16'h0084, 1'b1);
    check_burst("t6_refill", 16'h0084, 1'b0);
    check("t6_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
